image_rx_pingpong: RTL and testbench

- Parametrised successor to the single-image UART input path.
- Receives pixel bytes over an asynchronous UART line and stores them into one of two image buffers (ping-pong), so image N+1 can stream in while the classifier reads image N.
- Adds a stop-bit framing check, an overrun report when no buffer is free, an optional inter-byte timeout resync, and an explicit consumer release handshake.
- Sits between the board UART pin and the network's input layer.

---
 rtl/img_rx_pkg.sv | 20 ++
 rtl/uart_rx_core.sv | 125 ++++++++++++
 rtl/image_rx_pingpong.sv | 149 ++++++++++++++
 tb/tb_image_rx_pingpong.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/img_rx_pkg.sv
// Purpose: shared constants, UART state type and baud helper for the ping-pong image receiver.
// Latency: none, this package holds declarations only.
// Backpressure: not applicable.
package img_rx_pkg;

   localparam int BYTE_W = 8;

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } uart_state_t;

   // Clock cycles per UART bit; truncating division.
   function automatic int bit_cycles(input int clk_hz, input int baud);
      return clk_hz / baud;
   endfunction

endpackage

// File: rtl/uart_rx_core.sv
// Purpose: 8N1 UART receiver with 2-flop rx synchroniser, mid-bit sampling and stop-bit check.
// Latency: byte_valid/frame_err are asserted in the cycle the stop bit is sampled.
// Backpressure: none; the consumer must take byte_data on the byte_valid cycle.
module uart_rx_core
   import img_rx_pkg::*;
#(
   parameter int CLK_HZ = 100_000_000,
   parameter int BAUD   = 9600
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              rx,
   output logic              byte_valid,
   output logic [BYTE_W-1:0] byte_data,
   output logic              frame_err,
   output logic              idle
);

   localparam int BIT_CYCLES  = bit_cycles(CLK_HZ, BAUD);
   localparam int HALF_CYCLES = BIT_CYCLES / 2;
   localparam int CNT_W       = $clog2(BIT_CYCLES + 1);
   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CYCLES - 1);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_CYCLES - 1);

   logic              sync1_q, sync2_q;
   logic              rx_s;
   uart_state_t       state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [2:0]        bit_idx_q, bit_idx_d;
   logic [BYTE_W-1:0] shift_q, shift_d;
   logic              stop_wait_q, stop_wait_d;

   assign rx_s = sync2_q;

   // Two-flop synchroniser; resets high so reset release never looks like a start bit.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
      end else begin
         sync1_q <= rx;
         sync2_q <= sync1_q;
      end
   end

   // Receiver state, baud counter, bit index and shift register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         bit_idx_q   <= '0;
         shift_q     <= '0;
         stop_wait_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         bit_idx_q   <= bit_idx_d;
         shift_q     <= shift_d;
         stop_wait_q <= stop_wait_d;
      end
   end

   // Next state; byte_valid and frame_err are decoded on the stop-bit sampling cycle.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      bit_idx_d   = bit_idx_q;
      shift_d     = shift_q;
      stop_wait_d = stop_wait_q;
      byte_valid  = 1'b0;
      frame_err   = 1'b0;
      case (state_q)
         IDLE: begin
            cnt_d       = '0;
            stop_wait_d = 1'b0;
            if (!rx_s) state_d = START;
         end
         START: begin
            if (cnt_q == HALF_LAST) begin
               cnt_d     = '0;
               bit_idx_d = '0;
               // A start bit that is high again at mid-bit was a glitch.
               state_d   = rx_s ? IDLE : DATA;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         DATA: begin
            if (cnt_q == BIT_LAST) begin
               cnt_d     = '0;
               shift_d   = {rx_s, shift_q[BYTE_W-1:1]};
               bit_idx_d = bit_idx_q + 3'd1;
               if (bit_idx_q == 3'd7) state_d = STOP;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         STOP: begin
            if (stop_wait_q) begin
               // Broken frame: hold here until the line returns to idle.
               if (rx_s) begin
                  state_d     = IDLE;
                  stop_wait_d = 1'b0;
               end
            end else if (cnt_q == BIT_LAST) begin
               cnt_d = '0;
               if (rx_s) begin
                  byte_valid = 1'b1;
                  state_d    = IDLE;
               end else begin
                  frame_err   = 1'b1;
                  stop_wait_d = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign byte_data = shift_q;
   assign idle      = (state_q == IDLE);

endmodule

// File: rtl/image_rx_pingpong.sv
// Purpose: UART image receiver filling two ping-pong image buffers for the classifier input layer.
// Latency: image_ready one cycle after the final stop-bit sample; rd_data/rd_valid one cycle after rd_en.
// Backpressure: none on the UART; a byte arriving while both buffers are full is dropped and flagged by overrun.
module image_rx_pingpong
   import img_rx_pkg::*;
#(
   parameter int CLK_HZ       = 100_000_000,
   parameter int BAUD         = 9600,
   parameter int IMG_PIXELS   = 784,
   parameter int ADDR_W       = $clog2(IMG_PIXELS),
   parameter int TIMEOUT_BITS = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              rx,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   input  logic              image_release,
   output logic [BYTE_W-1:0] rd_data,
   output logic              rd_valid,
   output logic              image_ready,
   output logic              frame_err,
   output logic              overrun,
   output logic [ADDR_W:0]   wr_count
);

   localparam int BIT_CYCLES = bit_cycles(CLK_HZ, BAUD);
   localparam bit TO_EN      = (TIMEOUT_BITS > 0);
   localparam int TO_CYCLES  = TO_EN ? TIMEOUT_BITS * BIT_CYCLES : 1;
   localparam int TO_W       = $clog2(TO_CYCLES + 1);
   localparam logic [TO_W-1:0]   TO_LAST  = TO_W'(TO_CYCLES - 1);
   localparam logic [ADDR_W:0]   PIX_N    = (ADDR_W + 1)'(IMG_PIXELS);
   localparam logic [ADDR_W:0]   PIX_LAST = (ADDR_W + 1)'(IMG_PIXELS - 1);

   logic              byte_valid;
   logic [BYTE_W-1:0] byte_data;
   logic              core_ferr;
   logic              rx_idle;

   logic [BYTE_W-1:0] mem [2][IMG_PIXELS];

   logic [1:0]        full_q, full_d;
   logic              wr_buf_q, wr_buf_d;
   logic              rd_buf_q, rd_buf_d;
   logic [ADDR_W:0]   wr_count_q, wr_count_d;
   logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
   logic [BYTE_W-1:0] rd_data_q, rd_data_d;
   logic              rd_valid_q, rd_valid_d;
   logic              wr_en;
   logic              ovr_pulse;
   logic              timeout;

   uart_rx_core #(
      .CLK_HZ (CLK_HZ),
      .BAUD   (BAUD)
   ) u_uart (
      .clk        (clk),
      .reset      (reset),
      .rx         (rx),
      .byte_valid (byte_valid),
      .byte_data  (byte_data),
      .frame_err  (core_ferr),
      .idle       (rx_idle)
   );

   // Pointers, full flags, timeout counter and read register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         full_q     <= '0;
         wr_buf_q   <= 1'b0;
         rd_buf_q   <= 1'b0;
         wr_count_q <= '0;
         to_cnt_q   <= '0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         full_q     <= full_d;
         wr_buf_q   <= wr_buf_d;
         rd_buf_q   <= rd_buf_d;
         wr_count_q <= wr_count_d;
         to_cnt_q   <= to_cnt_d;
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
      end
   end

   // Pixel storage; contents survive reset on purpose.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_buf_q][wr_count_q[ADDR_W-1:0]] <= byte_data;
   end

   // Write, timeout, release and read decisions, all taken from pre-edge state.
   always_comb begin
      full_d     = full_q;
      wr_buf_d   = wr_buf_q;
      rd_buf_d   = rd_buf_q;
      wr_count_d = wr_count_q;
      to_cnt_d   = '0;
      rd_data_d  = rd_data_q;
      rd_valid_d = 1'b0;
      wr_en      = 1'b0;
      ovr_pulse  = 1'b0;
      timeout    = 1'b0;

      if (byte_valid) begin
         if (full_q[wr_buf_q]) begin
            ovr_pulse = 1'b1;
         end else begin
            wr_en = 1'b1;
            if (wr_count_q == PIX_LAST) begin
               full_d[wr_buf_q] = 1'b1;
               wr_buf_d         = ~wr_buf_q;
               wr_count_d       = '0;
            end else begin
               wr_count_d = wr_count_q + (ADDR_W + 1)'(1);
            end
         end
      end

      // Line idle too long mid-image: drop the partial image and resync.
      if (TO_EN && rx_idle && (wr_count_q != '0)) begin
         if (to_cnt_q == TO_LAST) begin
            timeout    = 1'b1;
            wr_count_d = '0;
         end else begin
            to_cnt_d = to_cnt_q + TO_W'(1);
         end
      end

      // Release can never target the buffer completing this cycle, so both may apply.
      if (image_release && full_q[rd_buf_q]) begin
         full_d[rd_buf_q] = 1'b0;
         rd_buf_d         = ~rd_buf_q;
      end

      if (rd_en && full_q[rd_buf_q]) begin
         rd_valid_d = 1'b1;
         rd_data_d  = ({1'b0, rd_addr} < PIX_N) ? mem[rd_buf_q][rd_addr] : '0;
      end
   end

   assign rd_data     = rd_data_q;
   assign rd_valid    = rd_valid_q;
   assign image_ready = full_q[rd_buf_q];
   assign wr_count    = wr_count_q;
   assign overrun     = ovr_pulse;
   assign frame_err   = core_ferr | timeout;

endmodule

// File: tb/tb_image_rx_pingpong.sv
// Purpose: randomized bench for image_rx_pingpong against an image-queue reference model.
// Latency: reads sampled one cycle after rd_en; pulses counted on every falling clock edge.
// Backpressure: models overrun as dropped bytes when two complete images are pending.
module tb_image_rx_pingpong;

   localparam int CLK_HZ = 1_000_000;
   localparam int BAUD   = 100_000;
   localparam int BITC   = 10;
   localparam int PIX    = 16;
   localparam int AW     = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // DUT A: timeout disabled
   logic          rst_n, rx, rd_en, img_rel;
   logic [AW-1:0] rd_addr;
   logic [7:0]    rd_data;
   logic          rd_valid, image_ready, frame_err, overrun;
   logic [AW:0]   wr_count;

   // DUT B: timeout of 20 bit-times
   logic          rst_n_b, rx_b, rd_en_b, img_rel_b;
   logic [AW-1:0] rd_addr_b;
   logic [7:0]    rd_data_b;
   logic          rd_valid_b, image_ready_b, frame_err_b, overrun_b;
   logic [AW:0]   wr_count_b;

   image_rx_pingpong #(
      .CLK_HZ(CLK_HZ), .BAUD(BAUD), .IMG_PIXELS(PIX), .ADDR_W(AW), .TIMEOUT_BITS(0)
   ) dut (
      .clk(clk), .reset(rst_n), .rx(rx), .rd_en(rd_en), .rd_addr(rd_addr),
      .image_release(img_rel), .rd_data(rd_data), .rd_valid(rd_valid),
      .image_ready(image_ready), .frame_err(frame_err), .overrun(overrun), .wr_count(wr_count)
   );

   image_rx_pingpong #(
      .CLK_HZ(CLK_HZ), .BAUD(BAUD), .IMG_PIXELS(PIX), .ADDR_W(AW), .TIMEOUT_BITS(20)
   ) dut_to (
      .clk(clk), .reset(rst_n_b), .rx(rx_b), .rd_en(rd_en_b), .rd_addr(rd_addr_b),
      .image_release(img_rel_b), .rd_data(rd_data_b), .rd_valid(rd_valid_b),
      .image_ready(image_ready_b), .frame_err(frame_err_b), .overrun(overrun_b), .wr_count(wr_count_b)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Pulse counters
   int fe_cnt = 0, ov_cnt = 0, fe_cnt_b = 0;
   always @(negedge clk) begin
      if (frame_err === 1'b1)   fe_cnt++;
      if (overrun === 1'b1)     ov_cnt++;
      if (frame_err_b === 1'b1) fe_cnt_b++;
   end

   // Reference model: completed images in arrival order, PIX bytes each, plus the partial one
   logic [7:0] ready_q[$];
   logic [7:0] cur_q[$];
   logic [7:0] last_rd;
   logic       rdy_at_stop;

   task automatic set_rx(input bit to_b, input logic v);
      if (to_b) rx_b = v;
      else      rx   = v;
   endtask

   task automatic serial(input bit to_b, input logic [7:0] data, input logic stop_bit);
      set_rx(to_b, 1'b0);
      repeat (BITC) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         set_rx(to_b, data[i]);
         repeat (BITC) @(negedge clk);
      end
      rdy_at_stop = to_b ? image_ready_b : image_ready;
      set_rx(to_b, stop_bit);
      repeat (BITC) @(negedge clk);
      set_rx(to_b, 1'b1);
   endtask

   task automatic send_a(input logic [7:0] b);
      int ov0;
      bit exp_ov, completes;
      ov0       = ov_cnt;
      exp_ov    = (ready_q.size() == 2 * PIX);
      completes = !exp_ov && (cur_q.size() == PIX - 1);
      serial(1'b0, b, 1'b1);
      if (!exp_ov) begin
         cur_q.push_back(b);
         if (cur_q.size() == PIX) begin
            foreach (cur_q[i]) ready_q.push_back(cur_q[i]);
            cur_q.delete();
         end
      end
      check("overrun_pulses", ov_cnt - ov0, exp_ov);
      check("wr_count", wr_count, cur_q.size());
      check("image_ready", image_ready, ready_q.size() != 0);
      if (completes && ready_q.size() == PIX) check("ready_before_stop", rdy_at_stop, 0);
      repeat ($urandom_range(0, 3)) @(negedge clk);
   endtask

   task automatic release_a();
      img_rel = 1'b1;
      @(negedge clk);
      img_rel = 1'b0;
      if (ready_q.size() != 0) repeat (PIX) void'(ready_q.pop_front());
      check("ready_after_release", image_ready, ready_q.size() != 0);
   endtask

   task automatic read_a(input int a, input bit with_release);
      logic [7:0] exp_d;
      bit         exp_v;
      exp_v   = (ready_q.size() != 0);
      exp_d   = exp_v ? ready_q[a] : last_rd;
      rd_addr = a[AW-1:0];
      rd_en   = 1'b1;
      img_rel = with_release;
      @(negedge clk);
      rd_en   = 1'b0;
      img_rel = 1'b0;
      check("rd_valid", rd_valid, exp_v);
      check("rd_data", rd_data, exp_d);
      if (exp_v) last_rd = exp_d;
      if (with_release && exp_v) begin
         repeat (PIX) void'(ready_q.pop_front());
         check("ready_after_rd_release", image_ready, ready_q.size() != 0);
      end
   endtask

   initial begin
      #600000;
      $display("FAIL watchdog: simulation exceeded its time budget");
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      int         fe0;
      logic [7:0] img_b [PIX];

      rst_n = 1'b0; rx = 1'b1; rd_en = 1'b0; img_rel = 1'b0; rd_addr = '0;
      rst_n_b = 1'b0; rx_b = 1'b1; rd_en_b = 1'b0; img_rel_b = 1'b0; rd_addr_b = '0;
      last_rd = 8'h00;
      rdy_at_stop = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_image_ready", image_ready, 0);
      check("reset_wr_count", wr_count, 0);
      check("reset_rd_valid", rd_valid, 0);
      check("reset_rd_data", rd_data, 0);
      check("reset_flags", {frame_err, overrun}, 0);
      rst_n = 1'b1; rst_n_b = 1'b1;
      repeat (5) @(negedge clk);

      // Ramp image, sequential read-back
      for (int i = 0; i < PIX; i++) send_a(8'(i));
      for (int a = 0; a < PIX; a++) read_a(a, 1'b0);
      release_a();
      read_a($urandom_range(0, PIX - 1), 1'b0);   // no image: rd_data must hold

      // Two queued images, read across a release
      for (int i = 0; i < PIX; i++) send_a(8'hA5);
      for (int i = 0; i < PIX; i++) send_a(8'h3C);
      for (int i = 0; i < 3; i++) read_a($urandom_range(0, PIX - 1), 1'b0);
      read_a($urandom_range(0, PIX - 1), 1'b1);   // read sees pre-release buffer
      for (int i = 0; i < 3; i++) read_a($urandom_range(0, PIX - 1), 1'b0);
      release_a();

      // Overrun with both buffers full
      for (int i = 0; i < 2 * PIX; i++) send_a(8'($urandom));
      send_a(8'h77);
      release_a();
      send_a(8'h77);

      // Stop bit low
      fe0 = fe_cnt;
      serial(1'b0, 8'h55, 1'b0);
      repeat (BITC) @(negedge clk);
      check("frame_err_pulses", fe_cnt - fe0, 1);
      check("wr_count_after_ferr", wr_count, cur_q.size());

      // Start-bit glitch of 3 cycles
      fe0 = fe_cnt;
      rx = 1'b0;
      repeat (3) @(negedge clk);
      rx = 1'b1;
      repeat (3 * BITC) @(negedge clk);
      check("glitch_frame_err", fe_cnt - fe0, 0);
      check("glitch_wr_count", wr_count, cur_q.size());
      send_a(8'($urandom));

      // Random mix of bytes, releases and reads
      for (int n = 0; n < 60; n++) begin
         case ($urandom_range(0, 5))
            0, 1, 2: send_a(8'($urandom));
            3:       release_a();
            default: read_a($urandom_range(0, PIX - 1), 1'b0);
         endcase
      end

      // Reset in the middle of a byte while a second image is filling
      while (ready_q.size() == 0 || cur_q.size() < 3) begin
         if (ready_q.size() == 2 * PIX) release_a();
         else send_a(8'($urandom));
      end
      read_a(PIX - 1, 1'b0);
      rx = 1'b0;
      repeat (35) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midreset_image_ready", image_ready, 0);
      check("midreset_wr_count", wr_count, 0);
      check("midreset_rd_data", rd_data, 0);
      check("midreset_rd_valid", rd_valid, 0);
      check("midreset_flags", {frame_err, overrun}, 0);
      repeat (2) @(negedge clk);
      rx = 1'b1;
      rst_n = 1'b1;
      ready_q.delete();
      cur_q.delete();
      last_rd = 8'h00;
      repeat (5) @(negedge clk);
      for (int i = 0; i < PIX; i++) send_a(8'($urandom));
      for (int a = 0; a < PIX; a++) read_a(a, 1'b0);

      // Inter-byte timeout on the second instance
      for (int i = 0; i < 5; i++) serial(1'b1, 8'($urandom), 1'b1);
      check("to_wr_count_partial", wr_count_b, 5);
      fe0 = fe_cnt_b;
      repeat (260) @(negedge clk);
      check("to_frame_err_pulses", fe_cnt_b - fe0, 1);
      check("to_wr_count_cleared", wr_count_b, 0);
      for (int i = 0; i < PIX; i++) begin
         img_b[i] = 8'($urandom);
         serial(1'b1, img_b[i], 1'b1);
      end
      check("to_image_ready", image_ready_b, 1);
      check("to_no_extra_ferr", fe_cnt_b - fe0, 1);
      for (int a = 0; a < PIX; a++) begin
         rd_addr_b = a[AW-1:0];
         rd_en_b = 1'b1;
         @(negedge clk);
         rd_en_b = 1'b0;
         check("to_rd_valid", rd_valid_b, 1);
         check("to_rd_data", rd_data_b, img_b[a]);
      end
      check("to_overrun", overrun_b, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
